// File: rtl/walu_pkg.sv
// walu_pkg: shared types and defaults for the WALU issue stage
package walu_pkg;
    localparam int WALU_ISSUE_DEPTH = 4;
    localparam int DATA_W = 16;
    typedef logic [DATA_W-1:0] data_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_t;
    typedef struct packed {
        data_t a;
        data_t b;
        op_t   op;
    } req_t;
endpackage

// File: rtl/walu_fifo.sv
// walu_fifo: circular request queue exposing its head entry
module walu_fifo
    import walu_pkg::*;
#(
    parameter int DEPTH = WALU_ISSUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  req_t                       din,
    output req_t                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    req_t mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // a full queue refuses a push even when the head pops in the same cycle
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/walu_issue.sv
// walu_issue: queues ALU requests, presents the head to the ALU and registers its result
module walu_issue
    import walu_pkg::*;
#(
    parameter int DEPTH = WALU_ISSUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  data_t                      in_a,
    input  data_t                      in_b,
    input  op_t                        in_op,
    output data_t                      alu_a,
    output data_t                      alu_b,
    output op_t                        alu_op,
    input  data_t                      alu_r,
    output logic                       out_valid,
    input  logic                       out_ready,
    output data_t                      out_r,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    req_t req, head;
    logic full, empty, issue;
    assign req = '{a: in_a, b: in_b, op: in_op};
    walu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(in_valid),
        .pop(issue),
        .din(req),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    assign in_ready = !full;
    assign issue = !empty && (!out_valid || out_ready);
    always_comb begin
        alu_a  = empty ? '0 : head.a;
        alu_b  = empty ? '0 : head.b;
        alu_op = empty ? OP_ADD : head.op;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_r     <= alu_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_walu_issue.sv
// tb_walu_issue: directed and random checks of walu_issue against a queue-level model
module tb_walu_issue;
    import walu_pkg::*;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH+1);
    typedef struct {
        data_t a;
        data_t b;
        op_t   op;
    } req_s;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    data_t in_a = '0, in_b = '0, alu_a, alu_b, alu_r, out_r;
    op_t in_op = OP_ADD, alu_op;
    logic [CW-1:0] count;
    int total = 0, bad = 0;
    req_s mq[$];
    logic mov = 0;
    data_t mor = '0;
    always #5 clk = ~clk;
    assign alu_r = alu_a + alu_b;
    walu_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_r(alu_r), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .count(count)
    );
    // one clock edge: the model decides from pre-edge inputs, then outputs settle
    task automatic step();
        bit acc, iss;
        req_s r;
        acc = in_valid && mq.size() < DEPTH;
        iss = mq.size() > 0 && (!mov || out_ready);
        r = '{a: in_a, b: in_b, op: in_op};
        @(posedge clk);
        if (iss) begin
            r = mq.pop_front();
            mor = r.a + r.b;
            mov = 1;
            r = '{a: in_a, b: in_b, op: in_op};
        end else if (mov && out_ready) mov = 0;
        if (acc) mq.push_back(r);
        #1;
    endtask
    task automatic test_reset();
        total += 7;
        if (count !== '0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_r !== '0) begin bad++; $display("FAIL reset_out_r got %0d want 0", out_r); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (alu_a !== '0) begin bad++; $display("FAIL reset_alu_a got %0d want 0", alu_a); end
        if (alu_b !== '0) begin bad++; $display("FAIL reset_alu_b got %0d want 0", alu_b); end
        if (alu_op !== OP_ADD) begin bad++; $display("FAIL reset_alu_op got %0d want 0", alu_op); end
    endtask
    task automatic test_single();
        out_ready = 1; in_valid = 1; in_a = 3; in_b = 4; in_op = OP_ADD;
        step();
        in_valid = 0;
        total += 6;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early got %b want 0", out_valid); end
        if (count !== CW'(1)) begin bad++; $display("FAIL single_count got %0d want 1", count); end
        step();
        if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", out_valid); end
        if (out_r !== 16'd7) begin bad++; $display("FAIL single_r got %0d want 7", out_r); end
        if (count !== '0) begin bad++; $display("FAIL single_count2 got %0d want 0", count); end
        step();
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_clear got %b want 0", out_valid); end
    endtask
    task automatic test_back_to_back();
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = i < 4;
            in_a = data_t'(i + 1); in_b = data_t'(i + 1);
            step();
            if (i > 0) begin
                total += 2;
                if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
                if (out_r !== data_t'(2 * i)) begin bad++; $display("FAIL b2b_r[%0d] got %0d want %0d", i, out_r, 2 * i); end
            end
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask
    task automatic test_full();
        data_t s[5];
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_a = data_t'($urandom); in_b = data_t'($urandom);
            s[i] = in_a + in_b;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_early[%0d] got %b want 1", i, in_ready); end
            step();
        end
        total += 4;
        if (count !== CW'(4)) begin bad++; $display("FAIL full_count got %0d want 4", count); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got %b want 1", out_valid); end
        if (out_r !== s[0]) begin bad++; $display("FAIL full_r got %0d want %0d", out_r, s[0]); end
        for (int i = 0; i < 3; i++) begin
            in_a = data_t'($urandom); in_b = data_t'($urandom);
            step();
            total += 2;
            if (count !== CW'(4)) begin bad++; $display("FAIL full_refuse_count got %0d want 4", count); end
            if (out_r !== s[0] || out_valid !== 1'b1) begin bad++; $display("FAIL full_hold got %0d want %0d", out_r, s[0]); end
        end
        out_ready = 1;
        step();
        in_valid = 0;
        total += 2;
        if (count !== CW'(3)) begin bad++; $display("FAIL full_pop_count got %0d want 3", count); end
        if (out_r !== s[1]) begin bad++; $display("FAIL full_pop_r got %0d want %0d", out_r, s[1]); end
        for (int k = 2; k < 5; k++) begin
            step();
            total++;
            if (out_r !== s[k]) begin bad++; $display("FAIL full_drain_r[%0d] got %0d want %0d", k, out_r, s[k]); end
        end
        step();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drain_valid got %b want 0", out_valid); end
        if (count !== '0) begin bad++; $display("FAIL full_drain_count got %0d want 0", count); end
    endtask
    task automatic test_reset_mid();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_a = data_t'($urandom); in_b = data_t'($urandom);
            step();
        end
        in_valid = 0;
        total += 2;
        if (count !== CW'(3)) begin bad++; $display("FAIL mid_pre_count got %0d want 3", count); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
        #2 rst_n = 0;
        #1;
        mq.delete(); mov = 0; mor = '0;
        total += 4;
        if (count !== '0) begin bad++; $display("FAIL mid_count got %0d want 0", count); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %b want 0", out_valid); end
        if (out_r !== '0) begin bad++; $display("FAIL mid_r got %0d want 0", out_r); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        #1 rst_n = 1;
        in_valid = 1; in_a = 10; in_b = 20; out_ready = 1;
        step();
        in_valid = 0;
        step();
        total += 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_after_valid got %b want 1", out_valid); end
        if (out_r !== 16'd30) begin bad++; $display("FAIL mid_after_r got %0d want 30", out_r); end
        step();
    endtask
    task automatic test_random();
        data_t exp[$];
        int acc_n = 0, got_n = 0, cyc = 0;
        data_t ea, eb;
        op_t eo;
        while ((acc_n < 2 * DEPTH + 1 || got_n < acc_n) && cyc < 2000) begin
            in_valid = (acc_n < 2 * DEPTH + 1) && ($urandom_range(0, 1) == 1);
            in_a = data_t'($urandom); in_b = data_t'($urandom);
            in_op = op_t'($urandom_range(0, 3));
            out_ready = $urandom_range(0, 2) != 0;
            if (in_valid && mq.size() < DEPTH) begin exp.push_back(in_a + in_b); acc_n++; end
            if (out_valid && out_ready) begin
                total++;
                if (out_r !== exp[got_n]) begin bad++; $display("FAIL rnd_order[%0d] got %0d want %0d", got_n, out_r, exp[got_n]); end
                got_n++;
            end
            step();
            cyc++;
            ea = mq.size() > 0 ? mq[0].a : '0;
            eb = mq.size() > 0 ? mq[0].b : '0;
            eo = mq.size() > 0 ? mq[0].op : OP_ADD;
            total += 5;
            if (count !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count got %0d want %0d", count, mq.size()); end
            if (in_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_in_ready got %b", in_ready); end
            if (out_valid !== mov) begin bad++; $display("FAIL rnd_valid got %b want %b", out_valid, mov); end
            if (out_r !== mor) begin bad++; $display("FAIL rnd_r got %0d want %0d", out_r, mor); end
            if (alu_a !== ea || alu_b !== eb || alu_op !== eo) begin
                bad++; $display("FAIL rnd_alu got %0d/%0d/%0d want %0d/%0d/%0d", alu_a, alu_b, alu_op, ea, eb, eo);
            end
        end
        if (out_valid && out_ready) got_n += 0;
        total++;
        if (got_n != 2 * DEPTH + 1) begin bad++; $display("FAIL rnd_complete got %0d want %0d", got_n, 2 * DEPTH + 1); end
    endtask
    initial begin
        #12;
        test_reset();
        #1 rst_n = 1;
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/walu_issue.md
WALU_ISSUE -- requirements
Module: walu_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning request-queue entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream request valid.
REQ-005 SHALL have port in_ready  output  1  queue can accept a request.
REQ-006 SHALL have port in_a, in_b  input  data_t  request operands.
REQ-007 SHALL have port in_op  input  op_t  request operation.
REQ-008 SHALL have port alu_a, alu_b  output  data_t  operands driven to the ALU.
REQ-009 SHALL have port alu_op  output  op_t  operation driven to the ALU.
REQ-010 SHALL have port alu_r  input  data_t  combinational ALU result for the current alu_a/alu_b/alu_op.
REQ-011 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_r  output  data_t  registered result.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  number of queued requests.

Function
REQ-015 SHALL push {in_a,in_b,in_op} at a rising edge iff in_valid && in_ready.
REQ-016 SHALL drive in_ready = (count < DEPTH); a full queue SHALL refuse a push even when a pop occurs in the same cycle.
REQ-017 SHALL drive alu_a/alu_b/alu_op combinationally from the queue head when count > 0, else all-zero operands and the first op_t encoding.
REQ-018 SHALL define issue = (count > 0) && (!out_valid || out_ready).
REQ-019 SHALL, on issue, load out_r <= alu_r, set out_valid <= 1, and pop the head in the same edge.
REQ-020 SHALL clear out_valid when out_valid && out_ready && !issue; out_r SHALL hold its value otherwise.
REQ-021 SHALL update count by +1 (push only), -1 (pop only), or 0 (both or neither).
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
REQ-023 SHALL have minimum latency of 2 edges from request acceptance to out_valid (accepted at edge N with an empty queue, out_valid high after edge N+1).
REQ-024 SHALL sustain one result per cycle when in_valid and out_ready are held high.
REQ-025 SHALL preserve request order; out_r sequence equals the ALU results of accepted requests in acceptance order.
REQ-026 SHALL keep out_r and out_valid stable while out_valid && !out_ready (no drop, no overwrite).

Reset
REQ-027 SHALL, while rst_n = 0, force count = 0, pointers = 0, out_valid = 0, out_r = 0, in_ready = 1, and alu_* to the empty values of REQ-017.
REQ-028 SHALL discard all queued requests and any pending result on reset assertion mid-operation; first push after release behaves as from an empty queue.

Structure
REQ-029 SHALL take data_t and op_t from walu_pkg; the default queue depth SHALL be a walu_pkg constant WALU_ISSUE_DEPTH = 4.
REQ-030 SHALL implement the queue as sub-module walu_fifo (push/pop/full/empty/count, head output); issue and result-register logic SHALL live in walu_issue.

Verification (bench ALU stub: alu_r = alu_a + alu_b)
REQ-031 Single request a=3, b=4 into an empty queue, out_ready=1 -> out_valid high 2 edges after acceptance with out_r=7, then low next cycle.
REQ-032 Back-to-back pushes of (1,1),(2,2),(3,3),(4,4) with out_ready=1 -> out_r = 2,4,6,8 on consecutive cycles, no bubbles.
REQ-033 out_ready=0, push 5 requests -> the first issues into out_r, the next 4 fill the queue (count=4, in_ready=0), and the 6th request is not accepted; out_r holds until out_ready=1.
REQ-034 Full queue, in_valid=1 and out_ready=1 in the same cycle -> pop occurs, push refused, count goes 4->3.
REQ-035 rst_n pulsed low with count=3 and out_valid=1 -> count=0, out_valid=0, out_r=0 immediately (asynchronously); next request (10,20) yields out_r=30.
REQ-036 Push 2*DEPTH+1 requests with random out_ready -> results in order, pointer wrap-around correct, no loss or duplication.
